// File: rtl/traditional_multiplier8_xor_enc64.sv
// ============================================================================
// Module  : traditional_multiplier8_xor_enc64
// Brief   : 8x8 unsigned multiplier, 64 key-locked partial products, registered
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module traditional_multiplier8_xor_enc64 #(
  parameter logic [63:0] K0 = 64'h192F7F0351667DEC
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  operand1_i,
  input  logic [7:0]  operand2_i,
  input  logic [63:0] keyinput,
  output logic [15:0] result_o
);

  logic [63:0] w_pp;
  logic [63:0] w_ppx;
  logic [15:0] w_sum;
  logic [15:0] r_result;

  // Row i holds a[7:0] & b[i], so net n = 8*i + j lands at w_pp[n].
  for (genvar i = 0; i < 8; i++) begin : g_row
    assign w_pp[8*i +: 8] = operand1_i & {8{operand2_i[i]}};
  end

  // XOR with a constant K0 bit folds to XOR (bit 0) or XNOR (bit 1).
  // Net 18 carries the gates for both keys 18 and 53; net 53 is left bare.
  for (genvar n = 0; n < 64; n++) begin : g_gate
    if (n == 18) begin : g_chain
      logic w_stage;
      assign w_stage  = w_pp[18] ^ keyinput[18] ^ K0[18];
      assign w_ppx[n] = w_stage  ^ keyinput[53] ^ K0[53];
    end else if (n == 53) begin : g_bare
      assign w_ppx[n] = w_pp[n];
    end else begin : g_single
      assign w_ppx[n] = w_pp[n] ^ keyinput[n] ^ K0[n];
    end
  end

  // Array reduction: row i is shifted by i; the worst-case total is 65025.
  always_comb begin
    w_sum = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      w_sum = w_sum + (16'(w_ppx[8*i +: 8]) << i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_result <= 16'h0000;
    end else begin
      r_result <= w_sum;
    end
  end

  assign result_o = r_result;

endmodule

`default_nettype wire

// File: tb/tb_traditional_multiplier8_xor_enc64.sv
// ============================================================================
// Module  : tb_traditional_multiplier8_xor_enc64
// Brief   : randomized self-checking bench against an arithmetic key model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_traditional_multiplier8_xor_enc64;

  localparam logic [63:0] C_K0  = 64'h192F7F0351667DEC;
  localparam logic [63:0] C_ALT = 64'h190F7F0351627DEC;

  logic        clk;
  logic        rst_n;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [63:0] key;
  logic [15:0] result;

  int checks = 0;
  int errors = 0;

  traditional_multiplier8_xor_enc64 #(.K0(C_K0)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .operand1_i (a),
    .operand2_i (b),
    .keyinput   (key),
    .result_o   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Product plus a signed correction for every net whose effective key is wrong.
  function automatic logic [15:0] ref_model(input logic [7:0] fa, input logic [7:0] fb,
                                            input logic [63:0] fk);
    logic [63:0] d;
    int          s;
    logic        flip;
    d = fk ^ C_K0;
    s = int'(fa) * int'(fb);
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        flip = d[8*i + j];
        if (8*i + j == 53) flip = 1'b0;
        if (8*i + j == 18) flip = d[18] ^ d[53];
        if (flip) begin
          if (fa[j] && fb[i]) s = s - (1 << (i + j));
          else                s = s + (1 << (i + j));
        end
      end
    end
    return s[15:0];
  endfunction

  // Apply one operand set at the falling edge and sample just after the next rising edge.
  task automatic drive_edge(input logic [7:0] na, input logic [7:0] nb, input logic [63:0] nk);
    @(negedge clk);
    a   = na;
    b   = nb;
    key = nk;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a     = 8'hFF;
    b     = 8'hFF;
    key   = C_K0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== 16'h0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0000", c, result);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    logic [7:0]  va [5] = '{8'h29, 8'h89, 8'h80, 8'hAB, 8'h24};
    logic [7:0]  vb [5] = '{8'h7A, 8'hFF, 8'h80, 8'h00, 8'h92};
    logic [15:0] vr [5] = '{16'h138A, 16'h8877, 16'h4000, 16'h0000, 16'h1488};
    for (int k = 0; k < 2; k++) begin
      for (int t = 0; t < 5; t++) begin
        drive_edge(va[t], vb[t], (k == 0) ? C_K0 : C_ALT);
        checks++;
        if (result !== vr[t]) begin
          errors++;
          $display("FAIL vector key%0d %h*%h: got %h expected %h", k, va[t], vb[t], result, vr[t]);
        end
      end
    end
  endtask

  task automatic test_key_flips();
    drive_edge(8'h00, 8'h00, 64'h192F7F0351667DE8);
    checks++;
    if (result !== 16'h0004) begin
      errors++;
      $display("FAIL flip_bit2 00*00: got %h expected 0004", result);
    end
    drive_edge(8'h29, 8'h7A, 64'h192F7F0351667DE8);
    checks++;
    if (result !== 16'h138E) begin
      errors++;
      $display("FAIL flip_bit2 29*7A: got %h expected 138E", result);
    end
    drive_edge(8'h80, 8'h80, 64'h392F7F0351667DEC);
    checks++;
    if (result !== 16'h5000) begin
      errors++;
      $display("FAIL flip_bit61 80*80: got %h expected 5000", result);
    end
  endtask

  task automatic test_reset_midstream();
    drive_edge(8'h55, 8'hAA, C_K0);
    checks++;
    if (result !== 16'h3872) begin
      errors++;
      $display("FAIL mid_pre: got %h expected 3872", result);
    end
    @(negedge clk);
    a = 8'hFF;
    b = 8'hFF;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (result !== 16'h0000) begin
      errors++;
      $display("FAIL mid_async: got %h expected 0000", result);
    end
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      checks++;
      if (result !== 16'h0000) begin
        errors++;
        $display("FAIL mid_hold cycle %0d: got %h expected 0000", c, result);
      end
    end
    @(negedge clk);
    a     = 8'h55;
    b     = 8'hAA;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (result !== 16'h3872) begin
      errors++;
      $display("FAIL mid_release: got %h expected 3872", result);
    end
  endtask

  // Back-to-back random traffic: correct key, single-bit flips, then multi-bit flips.
  task automatic test_random();
    logic [7:0]  ra;
    logic [7:0]  rb;
    logic [63:0] rk;
    logic [15:0] exp_v;
    for (int t = 0; t < 10000; t++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      drive_edge(ra, rb, C_K0);
      checks++;
      if (result !== 16'(int'(ra) * int'(rb))) begin
        errors++;
        $display("FAIL rand_k0 %h*%h: got %h expected %h", ra, rb, result, 16'(int'(ra) * int'(rb)));
      end
      rk    = C_K0 ^ (64'd1 << $urandom_range(0, 63));
      exp_v = ref_model(ra, rb, rk);
      drive_edge(ra, rb, rk);
      checks++;
      if (result !== exp_v) begin
        errors++;
        $display("FAIL rand_flip1 %h*%h key %h: got %h expected %h", ra, rb, rk, result, exp_v);
      end
    end
    for (int t = 0; t < 2000; t++) begin
      ra    = 8'($urandom);
      rb    = 8'($urandom);
      rk    = {$urandom, $urandom};
      exp_v = ref_model(ra, rb, rk);
      drive_edge(ra, rb, rk);
      checks++;
      if (result !== exp_v) begin
        errors++;
        $display("FAIL rand_multi %h*%h key %h: got %h expected %h", ra, rb, rk, result, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_key_flips();
    test_reset_midstream();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/traditional_multiplier8_xor_enc64.md
TRADITIONAL_MULTIPLIER8_XOR_ENC64 -- requirements
Module: traditional_multiplier8_xor_enc64

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset, with ports as listed below.
REQ-002 Port clk_i  input  1: rising-edge clock.
REQ-003 Port rst_ni  input  1: asynchronous active-low reset.
REQ-004 Port operand1_i  input  8: unsigned multiplicand a.
REQ-005 Port operand2_i  input  8: unsigned multiplier b.
REQ-006 Port keyinput  input  64: logic-locking key k.
REQ-007 Port result_o  output  16: registered (locked) product.
REQ-008 Parameter K0, default 64'h192F7F0351667DEC: correct key constant, hard-wired into key-gate polarities; not a port.

Function
REQ-009 Partial products SHALL be pp[n] = a[j] & b[i] for n = 8*i + j, with i, j in 0..7, giving 64 nets.
REQ-010 Each key gate SHALL be XOR where the K0 bit is 0 and XNOR where it is 1, i.e. functionally ppx = pp ^ k[n] ^ K0[n].
REQ-011 Key gates SHALL be placed as follows:
- Every n except 18 and 53: ppx[n] = pp[n] ^ k[n] ^ K0[n].
- Net 18: ppx[18] = pp[18] ^ k[18] ^ k[53] ^ K0[18] ^ K0[53], a chain of two key gates.
- Net 53: ppx[53] = pp[53], no gate.
- Total key gates: 64.
REQ-012 The combinational sum S SHALL be sum over n of ppx[n] * 2^(i+j).
- Any reduction structure is allowed: array, Wallace, or carry-save with a final adder.
- The maximum value is 65025, so S never exceeds 16 bits and no truncation occurs.
REQ-013 With the correct key, S SHALL equal a*b exactly for all 65536 operand pairs.
REQ-014 The correct-key class SHALL be exactly two keys: K0, and K0 with bits 18 and 53 both inverted (64'h190F7F0351627DEC).
REQ-015 Flipping a single key bit n (n not 18 or 53) SHALL give S = a*b + (1 - 2*pp[n]) * 2^(i+j).
REQ-016 Flipping exactly one of bits 18 or 53 SHALL act on net 18 (i=2, j=2) by the REQ-015 formula.
REQ-017 Multiple flipped bits SHALL compose additively per net, following REQ-012.
REQ-018 On each rising clk_i edge with rst_ni high, result_o SHALL load S computed from the current operand1_i, operand2_i and keyinput.
REQ-019 Latency SHALL be 1 clock from input change to result_o, and throughput one product per cycle.
REQ-020 There SHALL be no handshake; inputs are sampled every edge and must be stable at the setup point.
REQ-021 A key change SHALL take effect at the next edge, with no key storage or retention.
REQ-022 No input or key register SHALL exist beyond the result_o register.

Reset
REQ-023 When rst_ni is low, result_o SHALL be 16'h0000 immediately, independent of clk_i.
REQ-024 While rst_ni is low, result_o SHALL hold 16'h0000 and ignore clock edges.
REQ-025 Reset assertion mid-stream SHALL discard the pending product.
REQ-026 The first rising edge after rst_ni goes high SHALL load S for the inputs present at that edge.
REQ-027 The combinational datapath SHALL have no reset.

Verification
REQ-028 Correct key K0, one edge per pair, result_o SHALL read:
- 0x29*0x7A -> 16'h138A
- 0x89*0xFF -> 16'h8877
- 0x80*0x80 -> 16'h4000
- 0xAB*0x00 -> 16'h0000
- 0x24*0x92 -> 16'h1488
REQ-029 Alternate key 64'h190F7F0351627DEC SHALL give results identical to K0 for every operand pair in REQ-028.
REQ-030 Key 64'h192F7F0351667DE8 (bit 2 flipped, net i=0, j=2) SHALL give:
- 0x00*0x00 -> 16'h0004
- 0x29*0x7A -> 16'h138E
REQ-031 Key 64'h392F7F0351667DEC (bit 61 flipped, net i=7, j=5) SHALL give 0x80*0x80 -> 16'h5000.
REQ-032 Reset scenario: run with K0, a=0x55, b=0xAA, and let result_o reach 16'h3872.
- Drop rst_ni between edges -> result_o SHALL be 16'h0000 at once and stay 0 across edges.
- Release rst_ni -> the first edge SHALL restore 16'h3872.
REQ-033 Random check: at least 10000 random operand pairs with K0 SHALL give result_o == a*b.
- The same pairs under random single-bit key flips SHALL match REQ-015 or REQ-016.
